// File: rtl/instr_fetch_unit_if.sv
// IF/ID handshake bundle between the fetch stage and decode.
// Fetch drives the held instruction; decode answers with ready.
interface instr_fetch_unit_if #(
   parameter int PC_WIDTH = 8
);
   logic                if_valid;
   logic [31:0]         if_instr;
   logic [PC_WIDTH-1:0] if_pc_plus4;
   logic                id_ready;

   modport master (
      output if_valid,
      output if_instr,
      output if_pc_plus4,
      input  id_ready
   );

   modport slave (
      input  if_valid,
      input  if_instr,
      input  if_pc_plus4,
      output id_ready
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads the instruction ROM and loads IF/ID.
// Handles stalls, jump/branch redirect with flush, and PC wrap-around.
module instr_fetch_unit #(
   parameter int                PC_WIDTH  = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC = 8'h00,
   parameter int                CNT_WIDTH = 16
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   output logic [PC_WIDTH-1:0]  o_pc_addr,
   input  logic [31:0]          i_imem_instr,
   input  logic                 i_branch_taken,
   input  logic [PC_WIDTH-1:0]  i_branch_base,
   input  logic [15:0]          i_branch_offset,
   input  logic                 i_jump,
   input  logic [25:0]          i_jump_target,
   output logic [CNT_WIDTH-1:0] o_fetch_count,
   instr_fetch_unit_if.master   ifid
);

   typedef enum logic {
      S_BOOT,
      S_RUN
   } state_t;

   state_t               r_state;
   logic [PC_WIDTH-1:0]  r_pc;
   logic                 r_valid;
   logic [31:0]          r_instr;
   logic [PC_WIDTH-1:0]  r_pc_plus4;
   logic [CNT_WIDTH-1:0] r_cnt;

   logic [PC_WIDTH-1:0]  w_pc_plus4;
   logic [31:0]          w_br_ext;
   logic [27:0]          w_jmp_full;
   logic [PC_WIDTH-1:0]  w_br_target;
   logic [PC_WIDTH-1:0]  w_jmp_target;
   logic [PC_WIDTH-1:0]  w_redir_pc;
   logic                 w_redirect;
   logic                 w_load;
   logic                 w_unused;

   assign w_pc_plus4   = r_pc + PC_WIDTH'(4);
   assign w_br_ext     = {{14{i_branch_offset[15]}},
                          i_branch_offset, 2'b00};
   assign w_jmp_full   = {i_jump_target, 2'b00};
   assign w_br_target  = i_branch_base + w_br_ext[PC_WIDTH-1:0];
   assign w_jmp_target = w_jmp_full[PC_WIDTH-1:0];
   assign w_redirect   = i_jump | i_branch_taken;
   assign w_load       = (!r_valid || ifid.id_ready) && !w_redirect;

   // Upper target bits fall outside the 256-byte ROM space.
   assign w_unused = ^{w_jmp_full[27:PC_WIDTH],
                       w_br_ext[31:PC_WIDTH]};

   always_comb begin
      w_redir_pc = w_br_target;
      if (i_jump) begin
         w_redir_pc = w_jmp_target;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= S_BOOT;
         r_pc       <= RESET_PC;
         r_valid    <= 1'b0;
         r_instr    <= '0;
         r_pc_plus4 <= '0;
         r_cnt      <= '0;
      end else begin
         unique case (r_state)
            S_BOOT: begin
               r_state <= S_RUN;
            end
            S_RUN: begin
               // Flush wins over a stall: the held word is wrong-path.
               if (w_redirect) begin
                  r_pc    <= w_redir_pc;
                  r_valid <= 1'b0;
               end else if (w_load) begin
                  r_instr    <= i_imem_instr;
                  r_pc_plus4 <= w_pc_plus4;
                  r_valid    <= 1'b1;
                  r_pc       <= w_pc_plus4;
                  r_cnt      <= r_cnt + CNT_WIDTH'(1);
               end
            end
            default: begin
               r_state <= S_BOOT;
            end
         endcase
      end
   end

   assign o_pc_addr        = r_pc;
   assign o_fetch_count    = r_cnt;
   assign ifid.if_valid    = r_valid;
   assign ifid.if_instr    = r_instr;
   assign ifid.if_pc_plus4 = r_pc_plus4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed stimulus, transfers checked
// by a scoreboard monitor, PC/counter state checked after each edge.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  pc_addr;
   logic [31:0] imem;
   logic        br;
   logic [7:0]  base;
   logic [15:0] off;
   logic        jmp;
   logic [25:0] jtgt;
   logic [15:0] cnt;
   logic        mon_en;

   int n_chk = 0;
   int n_err = 0;

   typedef struct packed {
      logic [31:0] instr;
      logic [7:0]  pcp4;
   } xfer_t;

   xfer_t sb[$];

   instr_fetch_unit_if #(.PC_WIDTH(8)) ifid ();

   instr_fetch_unit dut (
      .i_clk           (clk),
      .i_reset         (rst),
      .o_pc_addr       (pc_addr),
      .i_imem_instr    (imem),
      .i_branch_taken  (br),
      .i_branch_base   (base),
      .i_branch_offset (off),
      .i_jump          (jmp),
      .i_jump_target   (jtgt),
      .o_fetch_count   (cnt),
      .ifid            (ifid.master)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [5:0] i);
      logic [31:0] w;
      case (i)
         6'd1:    w = 32'h8C08_0001;
         6'd3:    w = 32'h0000_0000;
         default: w = {16'hA5A5, 10'h0, i};
      endcase
      return w;
   endfunction

   assign imem = rom(pc_addr[7:2]);

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [5:0] idx, input logic [7:0] p4);
      xfer_t x;
      x.instr = rom(idx);
      x.pcp4  = p4;
      sb.push_back(x);
   endtask

   // Scoreboard: every accepted transfer must match the queue head.
   always @(negedge clk) begin
      if (mon_en && ifid.if_valid && ifid.id_ready) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL sb_unexpected: got %h/%h expected none",
                     ifid.if_instr, ifid.if_pc_plus4);
         end else begin
            xfer_t e;
            e = sb.pop_front();
            chk("sb_instr", ifid.if_instr, e.instr);
            chk("sb_pcp4", {24'h0, ifid.if_pc_plus4}, {24'h0, e.pcp4});
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      ifid.id_ready = 1'b0;
      br = 1'b0; base = '0; off = '0;
      jmp = 1'b0; jtgt = '0;
      mon_en = 1'b1;
      tick();
      tick();
      chk("rst_pc", {24'h0, pc_addr}, 32'h00);
      chk("rst_valid", {31'h0, ifid.if_valid}, 32'h0);
      chk("rst_instr", ifid.if_instr, 32'h0);
      chk("rst_pcp4", {24'h0, ifid.if_pc_plus4}, 32'h0);
      chk("rst_cnt", {16'h0, cnt}, 32'h0);

      // BOOT cycle: no load
      rst = 1'b0;
      ifid.id_ready = 1'b1;
      tick();
      chk("boot_pc", {24'h0, pc_addr}, 32'h00);
      chk("boot_valid", {31'h0, ifid.if_valid}, 32'h0);

      push(6'd0, 8'h04);
      push(6'd1, 8'h08);
      push(6'd2, 8'h0C);
      tick();
      chk("seq_pc04", {24'h0, pc_addr}, 32'h04);
      chk("seq_cnt1", {16'h0, cnt}, 32'd1);
      tick();
      chk("seq_pc08", {24'h0, pc_addr}, 32'h08);
      chk("seq_i1", ifid.if_instr, 32'h8C08_0001);
      chk("seq_p1", {24'h0, ifid.if_pc_plus4}, 32'h08);
      tick();
      chk("seq_pc0c", {24'h0, pc_addr}, 32'h0C);
      chk("seq_cnt3", {16'h0, cnt}, 32'd3);

      // stall for 3 cycles
      ifid.id_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stl_pc", {24'h0, pc_addr}, 32'h0C);
         chk("stl_instr", ifid.if_instr, rom(6'd2));
         chk("stl_pcp4", {24'h0, ifid.if_pc_plus4}, 32'h0C);
         chk("stl_cnt", {16'h0, cnt}, 32'd3);
         chk("stl_valid", {31'h0, ifid.if_valid}, 32'h1);
      end
      ifid.id_ready = 1'b1;
      push(6'd3, 8'h10);
      tick();
      chk("res_pc", {24'h0, pc_addr}, 32'h10);
      chk("res_cnt", {16'h0, cnt}, 32'd4);

      // branch: 0x18 + (-2 << 2) = 0x10
      br = 1'b1; base = 8'h18; off = 16'hFFFE;
      tick();
      chk("br_pc", {24'h0, pc_addr}, 32'h10);
      chk("br_valid", {31'h0, ifid.if_valid}, 32'h0);
      chk("br_cnt", {16'h0, cnt}, 32'd4);
      br = 1'b0;
      tick();
      chk("br_pcp4", {24'h0, ifid.if_pc_plus4}, 32'h14);
      chk("br_valid2", {31'h0, ifid.if_valid}, 32'h1);
      chk("br_cnt2", {16'h0, cnt}, 32'd5);

      // branch during stall still flushes
      ifid.id_ready = 1'b0;
      br = 1'b1;
      tick();
      chk("brs_pc", {24'h0, pc_addr}, 32'h10);
      chk("brs_valid", {31'h0, ifid.if_valid}, 32'h0);
      chk("brs_cnt", {16'h0, cnt}, 32'd5);
      br = 1'b0;
      tick();
      chk("brs_pc2", {24'h0, pc_addr}, 32'h14);
      chk("brs_cnt2", {16'h0, cnt}, 32'd6);

      // jump beats branch
      ifid.id_ready = 1'b1;
      push(6'd4, 8'h14);
      jmp = 1'b1; jtgt = 26'h000028; br = 1'b1;
      tick();
      chk("jb_pc", {24'h0, pc_addr}, 32'hA0);
      chk("jb_valid", {31'h0, ifid.if_valid}, 32'h0);
      jmp = 1'b0; br = 1'b0;
      tick();
      chk("jb_pc2", {24'h0, pc_addr}, 32'hA4);
      chk("jb_cnt", {16'h0, cnt}, 32'd7);

      // wrap from 0xFC
      push(6'd40, 8'hA4);
      jmp = 1'b1; jtgt = 26'h00003F;
      tick();
      chk("wr_pc", {24'h0, pc_addr}, 32'hFC);
      jmp = 1'b0;
      tick();
      chk("wr_pc2", {24'h0, pc_addr}, 32'h00);
      chk("wr_pcp4", {24'h0, ifid.if_pc_plus4}, 32'h00);
      chk("wr_cnt", {16'h0, cnt}, 32'd8);
      push(6'd63, 8'h00);
      tick();
      chk("wr_cnt9", {16'h0, cnt}, 32'd9);

      // run the counter up to its wrap point
      mon_en = 1'b0;
      repeat (65535 - 9) tick();
      chk("cnt_max", {16'h0, cnt}, 32'hFFFF);
      tick();
      chk("cnt_wrap", {16'h0, cnt}, 32'h0);

      // reset during stall with a pending branch
      ifid.id_ready = 1'b0;
      tick();
      rst = 1'b1; br = 1'b1; base = 8'h18; off = 16'hFFFE;
      tick();
      chk("mr_pc", {24'h0, pc_addr}, 32'h00);
      chk("mr_valid", {31'h0, ifid.if_valid}, 32'h0);
      chk("mr_cnt", {16'h0, cnt}, 32'h0);
      chk("mr_instr", ifid.if_instr, 32'h0);
      rst = 1'b0;
      ifid.id_ready = 1'b1;
      tick();
      chk("mr_boot_pc", {24'h0, pc_addr}, 32'h00);
      chk("mr_boot_v", {31'h0, ifid.if_valid}, 32'h0);
      chk("mr_boot_cnt", {16'h0, cnt}, 32'h0);
      br = 1'b0;
      mon_en = 1'b1;
      push(6'd0, 8'h04);
      tick();
      chk("mr_pc2", {24'h0, pc_addr}, 32'h04);
      chk("mr_cnt2", {16'h0, cnt}, 32'd1);
      tick();

      chk("sb_drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction memory in the single-cycle/pipelined MIPS core.
- Owns the program counter and drives the 8-bit byte address into the combinational instruction ROM, which indexes words by address[7:2].
- Captures the returned 32-bit word into an IF/ID register with a valid/ready handshake toward decode.
- Handles stall, branch and jump redirect, and PC wrap-around.

Parameters:
- PC_WIDTH, 8, width of the byte-address PC (ROM is 64 words, so PC_WIDTH must be 8).
- RESET_PC, 8'h00, PC value loaded on reset; must be word aligned.
- CNT_WIDTH, 16, width of the fetch counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- pc_addr  out  PC_WIDTH  current PC; drives the instruction memory address input
- imem_instr  in  32  combinational ROM output for pc_addr
- if_valid  out  1  IF/ID register holds a valid instruction
- if_instr  out  32  IF/ID instruction
- if_pc_plus4  out  PC_WIDTH  PC+4 of the held instruction
- id_ready  in  1  decode accepts if_instr this cycle
- branch_taken  in  1  branch redirect request
- branch_base  in  PC_WIDTH  PC+4 of the branching instruction
- branch_offset  in  16  signed word offset (MIPS imm16)
- jump  in  1  jump redirect request
- jump_target  in  26  MIPS J-type target field
- fetch_count  out  CNT_WIDTH  number of instructions loaded into IF/ID

Behaviour:
- Reset (sync, clk edge with reset=1):
  - pc_addr=RESET_PC, if_valid=0, if_instr=0, if_pc_plus4=0, fetch_count=0.
  - FSM enters BOOT.
- FSM states:
  - BOOT: first cycle after reset release. No load, PC held. Always goes to RUN next cycle.
  - RUN: normal operation.
  - Redirect requests are ignored in BOOT.
- Load condition in RUN: load = (!if_valid || id_ready) && !redirect.
- On a load edge:
  - if_instr <= imem_instr; if_pc_plus4 <= pc+4; if_valid <= 1.
  - pc <= pc+4; fetch_count <= fetch_count+1, wrapping.
- Handshake:
  - A transfer to decode occurs when if_valid && id_ready.
  - With if_valid=1 and id_ready=0 (stall): PC, if_instr, if_pc_plus4, if_valid and fetch_count all hold.
- Redirect (RUN only), priority jump > branch_taken:
  - Jump target: pc <= {jump_target[5:0], 2'b00}.
  - Branch target: pc <= branch_base + (sign_extend(branch_offset) << 2), truncated to PC_WIDTH bits (modulo 256).
  - Same edge: if_valid <= 0 (flush). This holds even if decode is stalled, because the held instruction is wrong-path.
  - if_instr and if_pc_plus4 are not cleared by a flush. fetch_count is not incremented.
- Latency:
  - Redirect to first valid target instruction at IF/ID: 1 edge to load PC, then 1 edge to load IF/ID.
  - Sequential fetch throughput: 1 instruction/cycle when id_ready=1.
- Wrap-around: pc+4 from 0xFC gives 0x00. if_pc_plus4 for 0xFC is 0x00.
- All PC values are word aligned by construction; bits [1:0] of pc_addr are always 0.
- A 32'h0 (nop) word is a normal valid instruction; it is not filtered.
- Reset asserted mid-operation overrides stall and redirect; the next edge gives reset values, and BOOT is re-entered.
- pc_addr is registered; the next-PC mux has no combinational path to pc_addr.

Test Plan:
- Reset then release, id_ready=1 -> pc_addr 0x00 in BOOT; IF/ID loads on the next edges.
  - pc_addr sequence 0x04, 0x08, 0x0C.
  - IF/ID word for PC 0x04 is 0x8C080001 with if_pc_plus4=0x08.
  - fetch_count increments each load.
- Stall: with if_valid=1 and if_pc_plus4=0x0C, hold id_ready=0 for 3 cycles.
  - pc_addr stays 0x0C; if_instr, if_pc_plus4 and fetch_count unchanged.
  - Releasing id_ready resumes at 0x0C with no instruction lost or duplicated.
- Branch: branch_taken=1, branch_base=0x18, branch_offset=16'hFFFE.
  - Next edge: pc_addr=0x10, if_valid=0.
  - Following edge: if_pc_plus4=0x14, if_valid=1.
  - Repeat during a stall; the flush must still occur.
- Jump+branch same cycle: jump=1, jump_target=26'h000028, branch_taken=1 -> pc_addr=0xA0; branch ignored.
- Wrap: jump to 0xFC (jump_target=26'h3F), id_ready=1 -> next pc_addr 0x00, if_pc_plus4=0x00, fetch_count wraps from 0xFFFF to 0x0000 when preset.
- Mid-run reset during a stall with a pending branch -> next edge: pc_addr=0x00, if_valid=0, fetch_count=0; one BOOT cycle with no load.
